// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB-Lite encodings, responder FSM state type and byte-lane decode.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables; lane 0 is bits 7:0.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lane;
      HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between the interconnect/master side and one responder.
interface ahb_lite_mem_slave_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_mem_slave_bytewr.sv
// DEPTH x 32 word memory with per-byte write enables and an asynchronous read port.
module ahb_mem_bytewr #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: wait-state FSM, address/control latch, error decode.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_lite_mem_slave_if.slave  bus
);
  localparam int unsigned     BYTE_AW    = $clog2(DEPTH * 4);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

  state_t             state, state_n;
  logic [2:0]         cnt, cnt_n, wait_n;
  logic [BYTE_AW-1:0] lat_addr;
  logic               lat_write;
  logic [3:0]         lat_be;
  logic [31:0]        hrdata_q, rdata_n, mem_rdata;
  logic               start, err, align_err;
  logic [3:0]         mem_we;
  logic               unused_hburst;

  assign unused_hburst = ^bus.hburst;

  assign start = bus.hsel && bus.hready && bus.htrans[1] &&
                 (state == ST_IDLE || state == ST_LAST || state == ST_ERR2);

  always_comb begin
    align_err = 1'b0;
    case (bus.hsize)
      HSIZE_BYTE: align_err = 1'b0;
      HSIZE_HALF: align_err = bus.haddr[0];
      HSIZE_WORD: align_err = |bus.haddr[1:0];
      default:    align_err = 1'b1;
    endcase
    err = align_err || (bus.haddr >= ADDR_LIMIT);
  end

  // LAST and ERR2 share IDLE's branch so a pipelined address phase re-enters without a bubble.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wait_n  = bus.hwrite ? 3'(WRITE_WAIT) : 3'(READ_WAIT);
    case (state)
      ST_WAIT: begin
        if (cnt <= 3'd1) begin
          state_n = ST_LAST;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      ST_ERR1: state_n = ST_ERR2;
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        if (start) begin
          if (err)                 state_n = ST_ERR1;
          else if (wait_n == '0)   state_n = ST_LAST;
          else begin
            state_n = ST_WAIT;
            cnt_n   = wait_n;
          end
        end
      end
    endcase
  end

  always_comb begin
    rdata_n = hrdata_q;
    if (!lat_write) begin
      if (state == ST_LAST)                            rdata_n = mem_rdata;
      else if (state == ST_ERR1 || state == ST_ERR2)   rdata_n = '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hrdata_q  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_be    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hrdata_q <= rdata_n;
      if (start) begin
        lat_addr  <= bus.haddr[BYTE_AW-1:0];
        lat_write <= bus.hwrite;
        lat_be    <= byte_en(bus.hsize, bus.haddr[1:0]);
      end
    end
  end

  assign mem_we = (state == ST_LAST && lat_write && !hreset) ? lat_be : '0;

  ahb_mem_bytewr #(.DEPTH(DEPTH)) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .waddr (lat_addr[BYTE_AW-1:2]),
    .wdata (bus.hwdata),
    .raddr (lat_addr[BYTE_AW-1:2]),
    .rdata (mem_rdata)
  );

  assign bus.hreadyout = !(state == ST_WAIT || state == ST_ERR1);
  assign bus.hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = rdata_n;
endmodule
